// File: rtl/onehot_pkg.sv
// ============================================================================
// Module      : onehot_pkg
// Description : Shared types and helpers for one-hot sequencers.
//               - action_e        : per-edge update selected by the counter
//               - is_onehot()     : true when exactly one bit is set
//               - onehot_lsb_index: index of the lowest set bit (0 if none)
//               Vectors are passed zero-extended to WIDTH_MAX bits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package onehot_pkg;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;
    localparam int IDX_W     = $clog2(WIDTH_MAX);

    // Update applied to the ring register at an edge (reset handled apart).
    typedef enum logic [2:0] {
        ACT_HOLD = 3'd0,
        ACT_LOAD = 3'd1,
        ACT_UP   = 3'd2,
        ACT_DOWN = 3'd3,
        ACT_FIX  = 3'd4
    } action_e;

    function automatic logic is_onehot(input logic [WIDTH_MAX-1:0] vec);
        int cnt;
        cnt = 0;
        for (int i = 0; i < WIDTH_MAX; i++) begin
            if (vec[i]) cnt++;
        end
        return (cnt == 1);
    endfunction

    // Scan from the top so the lowest set bit is the last one written.
    function automatic logic [IDX_W-1:0] onehot_lsb_index(input logic [WIDTH_MAX-1:0] vec);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = WIDTH_MAX - 1; i >= 0; i--) begin
            if (vec[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/onehot_to_bin.sv
// ============================================================================
// Module      : onehot_to_bin
// Description : Combinational one-hot to binary encoder with legality flag.
// Ports       : q   [WIDTH-1:0] in  - one-hot vector
//               pos [PW-1:0]    out - lowest set bit index (0 when q==0)
//               err             out - q does not have exactly one bit set
// Parameters  : WIDTH 2..32, PW derived as $clog2(WIDTH)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module onehot_to_bin
    import onehot_pkg::*;
#(
    parameter  int WIDTH = 5,
    localparam int PW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] q,
    output logic [PW-1:0]    pos,
    output logic             err
);

    logic [WIDTH_MAX-1:0] w_vec;
    logic [IDX_W-1:0]     w_idx;

    assign w_vec = WIDTH_MAX'(q);
    assign w_idx = onehot_lsb_index(w_vec);
    assign err   = ~is_onehot(w_vec);

    // The helper encodes into the widest index; keep only what WIDTH needs.
    generate
        if (PW == IDX_W) begin : g_pos_full
            assign pos = w_idx;
        end else begin : g_pos_trim
            logic [IDX_W-PW-1:0] w_unused_idx_hi;
            assign pos             = w_idx[PW-1:0];
            assign w_unused_idx_hi = w_idx[IDX_W-1:PW];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/onehot_ring_counter.sv
// ============================================================================
// Module      : onehot_ring_counter
// Description : Parametrised one-hot up/down ring counter with parallel load,
//               binary position, min/max flags, registered wrap pulse and
//               illegal-state detection. State updates on the falling edge.
//               Priority per edge: reset > load (legal index) > en > hold.
// Ports       : clk, reset (sync, active-high), en, up, load, load_pos[PW]
//               q[WIDTH], pos[PW], max, min, wrap, err
// Parameters  : WIDTH 2..32, RESET_POS 0..WIDTH-1, PW = $clog2(WIDTH)
// Options     : ONEHOT_SELF_CORRECT_EN - when defined, an illegal q is
//               replaced by the reset pattern on the next edge, overriding
//               load and en. Otherwise illegal patterns rotate/hold as-is.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module onehot_ring_counter
    import onehot_pkg::*;
#(
    parameter  int WIDTH     = 5,
    parameter  int RESET_POS = 0,
    localparam int PW        = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [PW-1:0]    load_pos,
    output logic [WIDTH-1:0] q,
    output logic [PW-1:0]    pos,
    output logic             max,
    output logic             min,
    output logic             wrap,
    output logic             err
);

    localparam logic [WIDTH-1:0] c_RESET_Q = WIDTH'(1) << RESET_POS;

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;

    action_e          w_act;
    logic             w_load_ok;
    logic             w_err;
    logic [WIDTH-1:0] w_q_next;
    logic             w_wrap_next;

    // load_pos can exceed WIDTH-1 when WIDTH is not a power of two; such a
    // load is dropped and the edge falls through to the count logic.
    assign w_load_ok = load && (int'({1'b0, load_pos}) < WIDTH);

    always_comb begin
        w_act = ACT_HOLD;
        if (w_load_ok) begin
            w_act = ACT_LOAD;
        end else if (en) begin
            w_act = up ? ACT_UP : ACT_DOWN;
        end
`ifdef ONEHOT_SELF_CORRECT_EN
        if (w_err) begin
            w_act = ACT_FIX;
        end
`endif
    end

    // Wrap is judged from the bit about to leave the ring end.
    always_comb begin
        w_q_next    = r_q;
        w_wrap_next = 1'b0;
        case (w_act)
            ACT_LOAD: w_q_next = WIDTH'(1) << load_pos;
            ACT_UP: begin
                w_q_next    = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                w_wrap_next = r_q[WIDTH-1];
            end
            ACT_DOWN: begin
                w_q_next    = {r_q[0], r_q[WIDTH-1:1]};
                w_wrap_next = r_q[0];
            end
            ACT_FIX:  w_q_next = c_RESET_Q;
            default:  w_q_next = r_q;
        endcase
    end

    always_ff @(negedge clk) begin
        if (reset) begin
            r_q    <= c_RESET_Q;
            r_wrap <= 1'b0;
        end else begin
            r_q    <= w_q_next;
            r_wrap <= w_wrap_next;
        end
    end

    onehot_to_bin #(
        .WIDTH (WIDTH)
    ) u_enc (
        .q   (r_q),
        .pos (pos),
        .err (w_err)
    );

    assign q    = r_q;
    assign wrap = r_wrap;
    assign err  = w_err;
    assign max  = r_q[WIDTH-1];
    assign min  = r_q[0];

endmodule

`default_nettype wire

// File: tb/tb_onehot_ring_counter.sv
// ============================================================================
// Module      : tb_onehot_ring_counter
// Description : Self-checking bench for onehot_ring_counter. Two instances:
//               A = WIDTH 5 / RESET_POS 0, B = WIDTH 8 / RESET_POS 3.
//               Vector table, hand sequences, illegal-state injection and a
//               randomised run against a modulo-position reference model.
//               Honours ONEHOT_SELF_CORRECT_EN for the illegal-state check.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_onehot_ring_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Instance A
    logic       a_rst = 1'b0, a_en = 1'b0, a_up = 1'b0, a_ld = 1'b0;
    logic [2:0] a_lp = '0;
    logic [4:0] a_q;
    logic [2:0] a_pos;
    logic       a_max, a_min, a_wrap, a_err;

    // Instance B
    logic       b_rst = 1'b0, b_en = 1'b0, b_up = 1'b0, b_ld = 1'b0;
    logic [2:0] b_lp = '0;
    logic [7:0] b_q;
    logic [2:0] b_pos;
    logic       b_max, b_min, b_wrap, b_err;

    onehot_ring_counter #(.WIDTH(5), .RESET_POS(0)) dut_a (
        .clk(clk), .reset(a_rst), .en(a_en), .up(a_up), .load(a_ld),
        .load_pos(a_lp), .q(a_q), .pos(a_pos), .max(a_max), .min(a_min),
        .wrap(a_wrap), .err(a_err)
    );

    onehot_ring_counter #(.WIDTH(8), .RESET_POS(3)) dut_b (
        .clk(clk), .reset(b_rst), .en(b_en), .up(b_up), .load(b_ld),
        .load_pos(b_lp), .q(b_q), .pos(b_pos), .max(b_max), .min(b_min),
        .wrap(b_wrap), .err(b_err)
    );

    typedef struct {
        logic       rst, en, up, ld;
        logic [2:0] lp;
        logic [4:0] q;
        logic [2:0] pos;
        logic       mx, mn, wr, er;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rst, en, up, ld, input logic [2:0] lp,
                       input logic [4:0] q, input logic [2:0] pos,
                       input logic mx, mn, wr);
        vec_t v;
        v.rst = rst; v.en = en; v.up = up; v.ld = ld; v.lp = lp;
        v.q = q; v.pos = pos; v.mx = mx; v.mn = mn; v.wr = wr; v.er = 1'b0;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: the counter is a position modulo w; wrap flags a crossing
    // of the w-1 <-> 0 boundary caused by counting.
    task automatic model_step(input int w, input int rp, input bit rst, ld, en, up,
                              input int lp, inout int p, inout bit wr);
        if (rst) begin
            p = rp; wr = 1'b0;
        end else if (ld && lp < w) begin
            p = lp; wr = 1'b0;
        end else if (en) begin
            if (up) begin
                wr = (p == w - 1);
                p  = (p + 1) % w;
            end else begin
                wr = (p == 0);
                p  = (p + w - 1) % w;
            end
        end else begin
            wr = 1'b0;
        end
    endtask

    task automatic step_b(input logic rst, en, up);
        @(posedge clk);
        b_rst = rst; b_en = en; b_up = up; b_ld = 1'b0; b_lp = '0;
        @(negedge clk); #1;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected end before 1000000");
        $fatal(1);
    end

    initial begin
        int pa, pb, lpa, lpb;
        bit wa, wb;

        //   rst en up ld lp   q         pos  mx mn wr
        add(1, 0, 0, 0, 0, 5'b00001, 0, 0, 1, 0);
        add(0, 1, 1, 0, 0, 5'b00010, 1, 0, 0, 0);
        add(0, 1, 1, 0, 0, 5'b00100, 2, 0, 0, 0);
        add(0, 1, 1, 0, 0, 5'b01000, 3, 0, 0, 0);
        add(0, 1, 1, 0, 0, 5'b10000, 4, 1, 0, 0);
        add(0, 1, 1, 0, 0, 5'b00001, 0, 0, 1, 1);
        add(0, 1, 1, 0, 0, 5'b00010, 1, 0, 0, 0);
        add(1, 1, 1, 0, 0, 5'b00001, 0, 0, 1, 0);
        add(0, 1, 0, 0, 0, 5'b10000, 4, 1, 0, 1);
        add(0, 1, 0, 0, 0, 5'b01000, 3, 0, 0, 0);
        add(0, 1, 0, 0, 0, 5'b00100, 2, 0, 0, 0);
        add(0, 1, 1, 1, 4, 5'b10000, 4, 1, 0, 0);
        add(0, 1, 0, 1, 7, 5'b01000, 3, 0, 0, 0);
        add(0, 0, 0, 1, 0, 5'b00001, 0, 0, 1, 0);
        add(0, 1, 0, 1, 5, 5'b10000, 4, 1, 0, 1);
        add(0, 1, 1, 1, 6, 5'b00001, 0, 0, 1, 1);
        add(0, 0, 1, 0, 0, 5'b00001, 0, 0, 1, 0);
        add(0, 0, 0, 1, 4, 5'b10000, 4, 1, 0, 0);
        add(0, 1, 1, 1, 0, 5'b00001, 0, 0, 1, 0);
        add(0, 1, 1, 0, 0, 5'b00010, 1, 0, 0, 0);

        foreach (vq[i]) begin
            @(posedge clk);
            a_rst = vq[i].rst; a_en = vq[i].en; a_up = vq[i].up;
            a_ld  = vq[i].ld;  a_lp = vq[i].lp;
            @(negedge clk); #1;
            chk($sformatf("vec%0d q", i),    32'(a_q),    32'(vq[i].q));
            chk($sformatf("vec%0d pos", i),  32'(a_pos),  32'(vq[i].pos));
            chk($sformatf("vec%0d max", i),  32'(a_max),  32'(vq[i].mx));
            chk($sformatf("vec%0d min", i),  32'(a_min),  32'(vq[i].mn));
            chk($sformatf("vec%0d wrap", i), 32'(a_wrap), 32'(vq[i].wr));
            chk($sformatf("vec%0d err", i),  32'(a_err),  32'(vq[i].er));
        end

        // WIDTH=8, RESET_POS=3: reset value, hold, count, reset mid-count.
        step_b(1, 0, 0);
        chk("b reset q", 32'(b_q), 32'h08);
        chk("b reset pos", 32'(b_pos), 3);
        chk("b reset wrap", 32'(b_wrap), 0);
        for (int i = 0; i < 4; i++) begin
            step_b(0, 0, 1);
            chk($sformatf("b hold%0d q", i), 32'(b_q), 32'h08);
        end
        for (int i = 0; i < 4; i++) begin
            step_b(0, 1, 1);
            chk($sformatf("b up%0d q", i), 32'(b_q), 32'h10 << i);
        end
        chk("b at msb max", 32'(b_max), 1);
        step_b(1, 1, 1);
        chk("b midreset q", 32'(b_q), 32'h08);
        chk("b midreset wrap", 32'(b_wrap), 0);

        // Illegal pattern injected into A.
        @(posedge clk);
        a_rst = 1'b0; a_en = 1'b0; a_ld = 1'b0;
        @(negedge clk); #1;
        force dut_a.r_q = 5'b00110;
        #1;
        chk("illegal err", 32'(a_err), 1);
        chk("illegal pos", 32'(a_pos), 1);
        release dut_a.r_q;
        @(posedge clk);
        a_en = 1'b1; a_up = 1'b1;
        @(negedge clk); #1;
`ifdef ONEHOT_SELF_CORRECT_EN
        chk("selfcorrect q", 32'(a_q), 32'b00001);
        chk("selfcorrect err", 32'(a_err), 0);
`else
        chk("illegal rot q", 32'(a_q), 32'b01100);
        chk("illegal rot err", 32'(a_err), 1);
`endif

        // Randomised run on both instances; first cycle resets.
        pa = 0; pb = 3; wa = 1'b0; wb = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(posedge clk);
            a_rst = (c == 0) || ($urandom_range(0, 49) == 0);
            b_rst = (c == 0) || ($urandom_range(0, 49) == 0);
            a_ld  = ($urandom_range(0, 7) == 0);
            b_ld  = ($urandom_range(0, 7) == 0);
            a_en  = ($urandom_range(0, 3) != 0);
            b_en  = ($urandom_range(0, 3) != 0);
            a_up  = 1'($urandom);
            b_up  = 1'($urandom);
            lpa   = $urandom_range(0, 7);
            lpb   = $urandom_range(0, 7);
            a_lp  = 3'(lpa);
            b_lp  = 3'(lpb);
            model_step(5, 0, a_rst, a_ld, a_en, a_up, lpa, pa, wa);
            model_step(8, 3, b_rst, b_ld, b_en, b_up, lpb, pb, wb);
            @(negedge clk); #1;
            chk($sformatf("rnd%0d a q", c),    32'(a_q),    32'(1) << pa);
            chk($sformatf("rnd%0d a pos", c),  32'(a_pos),  32'(pa));
            chk($sformatf("rnd%0d a wrap", c), 32'(a_wrap), 32'(wa));
            chk($sformatf("rnd%0d a err", c),  32'(a_err),  0);
            chk($sformatf("rnd%0d b q", c),    32'(b_q),    32'(1) << pb);
            chk($sformatf("rnd%0d b wrap", c), 32'(b_wrap), 32'(wb));
            chk($sformatf("rnd%0d b err", c),  32'(b_err),  0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/onehot_ring_counter.md
Name: onehot_ring_counter

Overview:
Parametrised one-hot ring counter. It generalises the 5-state up/down one-hot counter to WIDTH states. It adds:
- synchronous parallel load
- binary position output
- min/max flags
- a registered wrap pulse
- illegal-state detection
It is used as a state/phase sequencer and a modulo-WIDTH divider inside the lab datapath designs.

Parameters:
- WIDTH, 5, number of states and one-hot bits; legal range 2..32.
- RESET_POS, 0, bit index set on reset; legal range 0..WIDTH-1.
- PW, $clog2(WIDTH), width of the position and load buses; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on the falling edge.
- reset  input  1  synchronous, active-high.
- en  input  1  count enable.
- up  input  1  1 = rotate toward the MSB, 0 = rotate toward the LSB.
- load  input  1  synchronous parallel load strobe.
- load_pos  input  PW  bit index to load.
- q  output  WIDTH  one-hot state register.
- pos  output  PW  binary index of the set bit in q; combinational.
- max  output  1  q[WIDTH-1]==1; combinational.
- min  output  1  q[0]==1; combinational.
- wrap  output  1  registered one-cycle pulse on a wrap-around transition.
- err  output  1  q is not exactly one-hot; combinational.

Behaviour:
- Reset value: q = 1<<RESET_POS and wrap = 0. pos, max, min and err follow from q.
- Priority at each falling edge: reset > load > en > hold.
- load=1 with load_pos < WIDTH: q <= 1<<load_pos, wrap <= 0, independent of en.
- load=1 with load_pos >= WIDTH: load is ignored. The edge then behaves as if load=0, so en/up apply.
- en=0 with no load: q holds and wrap <= 0.
- en=1, up=1: q <= {q[WIDTH-2:0], q[WIDTH-1]}. Bit i moves to i+1; the MSB moves to bit 0.
- en=1, up=0: q <= {q[0], q[WIDTH-1:1]}. Bit i moves to i-1; bit 0 moves to the MSB.
- wrap <= 1 for exactly one cycle in these two cases, otherwise 0:
  - en=1, up=1 and q[WIDTH-1]=1 before the edge
  - en=1, up=0 and q[0]=1 before the edge
- wrap changes on the same edge as q, so it is aligned with the new q. Continuous counting produces one wrap pulse every WIDTH enabled cycles.
- Direction change is allowed on any cycle with no extra latency. For example, at q=MSB, up=0 moves to MSB-1 with no wrap.
- Latency: one edge from en, load or reset to q. Flags are combinational from q.
- pos:
  - index of the lowest set bit of q
  - 0 when q==0
  - defined for illegal states, but only meaningful when err=0
- err = 1 when popcount(q) != 1, i.e. zero bits set or more than one.
- Reset asserted mid-count wins unconditionally on that edge and clears wrap.
- WIDTH=2 degenerates to a toggling pair; max and min are mutually exclusive when err=0.

Optional Feature:
- Macro: ONEHOT_SELF_CORRECT_EN.
- Defined: at any edge where err=1 and reset=0, q <= 1<<RESET_POS and wrap <= 0. This overrides load and en, so recovery takes one edge.
- Undefined: illegal q rotates and holds like a legal one (bits preserved, no correction). err stays asserted until reset or load.
- err is present in both builds.

Decomposition:
- Package onehot_pkg holds:
  - function is_onehot(vec) -> bit
  - function onehot_lsb_index(vec) -> index, the lowest-set-bit encoder
  - localparam limits WIDTH_MIN=2 and WIDTH_MAX=32
- One sub-module: onehot_to_bin, a parametrised combinational encoder producing pos and err from q. It is reusable by other sequencers.
- The rotate/load register stays in onehot_ring_counter.

Test Plan:
- WIDTH=5 defaults; reset=1 for one edge, then en=1, up=1 for 6 edges:
  - q sequence 00001→00010→00100→01000→10000→00001
  - max=1 at 10000
  - wrap=1 only alongside the second 00001
  - pos sequence 0,1,2,3,4,0
- Down count from reset, en=1, up=0: q 00001→10000 with wrap=1, then 01000, 00100; min=1 only at 00001.
- At q=00100 apply load=1, load_pos=4 with en=1: q=10000, no rotate, wrap=0. Then load_pos=7 with en=1, up=0: load is ignored and q rotates to 01000.
- WIDTH=8, RESET_POS=3: after reset q=00001000 and pos=3. en=0 for 4 edges holds q. reset asserted during counting returns q to 00001000 on that edge with wrap=0.
- Force q=00110 via hierarchical deposit, WIDTH=5:
  - err=1 immediately
  - with ONEHOT_SELF_CORRECT_EN: next edge q=00001 and err=0
  - without it: next edge up=1 gives q=01100, err=1
- Randomised en/up/load for 1000 cycles against a binary mod-WIDTH reference model. Check:
  - q == 1<<model_pos
  - wrap matches model wrap
  - err never asserts
